// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the two requesters (ROM loader on A, CPU on B), the
// arbiter and the shared SPI SRAM encoder.
// slave  : the arbiter's view (requests and encoder status come in)
// master : the environment's view (requesters plus encoder)
interface sram_port_arbiter_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 16
);
  logic                     load_mode;
  logic                     a_req;
  logic                     a_we;
  logic [ADDRESS_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0]    a_wdata;
  logic                     a_ack;
  logic [DATA_WIDTH-1:0]    a_rdata;
  logic                     b_req;
  logic                     b_we;
  logic [ADDRESS_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0]    b_wdata;
  logic                     b_ack;
  logic [DATA_WIDTH-1:0]    b_rdata;
  logic                     mem_request;
  logic                     mem_busy;
  logic                     mem_initialized;
  logic [ADDRESS_WIDTH-1:0] mem_address;
  logic                     mem_write_enable;
  logic [DATA_WIDTH-1:0]    mem_write_data;
  logic [DATA_WIDTH-1:0]    mem_read_data;
  logic [1:0]               owner;

  modport slave (
    input  load_mode,
    input  a_req, a_we, a_addr, a_wdata,
    output a_ack, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_ack, b_rdata,
    output mem_request, mem_address, mem_write_enable, mem_write_data,
    input  mem_busy, mem_initialized, mem_read_data,
    output owner
  );

  modport master (
    output load_mode,
    output a_req, a_we, a_addr, a_wdata,
    input  a_ack, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_ack, b_rdata,
    input  mem_request, mem_address, mem_write_enable, mem_write_data,
    output mem_busy, mem_initialized, mem_read_data,
    input  owner
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter in front of one spi_sram_encoder.
// Port A (ROM loader) and port B (CPU) each get one transaction at a time;
// load_mode locks out port B. Read data returns with a one-cycle ack.
// Optional watchdog: define SRAM_ARB_TIMEOUT_EN to add a wait-state counter
// (TIMEOUT_CYCLES) that force-completes a stuck transaction with all-ones
// read data and sets the sticky timeout_err output.
//
// Timing: grant happens on the IDLE edge, the ISSUE cycle registers
// mem_request so the encoder sees it during the first WAIT_START cycle
// (two cycles after req rises). The owner's ack is registered on entry to
// COMPLETE, so it is high for exactly the COMPLETE cycle.
module sram_port_arbiter #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDRESS_WIDTH  = 16
`ifdef SRAM_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1023
`endif
) (
  input  logic clk,
  input  logic reset,
`ifdef SRAM_ARB_TIMEOUT_EN
  output logic timeout_err,
`endif
  sram_port_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_START, WAIT_DONE, COMPLETE
  } state_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_A    = 2'b01;
  localparam logic [1:0] OWN_B    = 2'b10;

  state_e                   state_q, state_d;
  logic [1:0]               owner_q, owner_d;
  logic                     last_b_q, last_b_d;  // 1: B was granted last
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                     we_q, we_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     mem_request_q, mem_request_d;
  logic                     a_ack_q, a_ack_d;
  logic                     b_ack_q, b_ack_d;
  logic [DATA_WIDTH-1:0]    a_rdata_q, a_rdata_d;
  logic [DATA_WIDTH-1:0]    b_rdata_q, b_rdata_d;
  logic                     elig_a, elig_b, pick_a;

`ifdef SRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             terr_q, terr_d;
  logic             in_wait;
`endif

  // Next-state, grant selection, data capture and registered-output values
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_b_d      = last_b_q;
    addr_d        = addr_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    mem_request_d = 1'b0;
    a_rdata_d     = a_rdata_q;
    b_rdata_d     = b_rdata_q;

    elig_a = bus.a_req;
    elig_b = bus.b_req & ~bus.load_mode;
    // On a tie the port that was not granted last wins
    pick_a = elig_a & (~elig_b | last_b_q);

    case (state_q)
      IDLE: begin
        if (bus.mem_initialized && !bus.mem_busy && (elig_a || elig_b)) begin
          state_d = ISSUE;
          if (pick_a) begin
            addr_d   = bus.a_addr;
            we_d     = bus.a_we;
            wdata_d  = bus.a_wdata;
            owner_d  = OWN_A;
            last_b_d = 1'b0;
          end else begin
            addr_d   = bus.b_addr;
            we_d     = bus.b_we;
            wdata_d  = bus.b_wdata;
            owner_d  = OWN_B;
            last_b_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        mem_request_d = 1'b1;
        state_d       = WAIT_START;
      end
      WAIT_START: begin
        if (bus.mem_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!bus.mem_busy) begin
          state_d = COMPLETE;
          if (!we_q) begin
            if (owner_q == OWN_A) a_rdata_d = bus.mem_read_data;
            if (owner_q == OWN_B) b_rdata_d = bus.mem_read_data;
          end
        end
      end
      COMPLETE: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
      default: state_d = IDLE;
    endcase

`ifdef SRAM_ARB_TIMEOUT_EN
    terr_d  = terr_q;
    in_wait = (state_q == WAIT_START) || (state_q == WAIT_DONE);
    // Watchdog only fires if the encoder did not move us on this cycle
    if (in_wait && (state_d == state_q) &&
        (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
      state_d = COMPLETE;
      terr_d  = 1'b1;
      if (owner_q == OWN_A) a_rdata_d = '1;
      if (owner_q == OWN_B) b_rdata_d = '1;
    end
    if (state_d != state_q) cnt_d = '0;
    else if (in_wait)       cnt_d = cnt_q + CNT_W'(1);
    else                    cnt_d = '0;
`endif

    a_ack_d = (state_d == COMPLETE) && (state_q != COMPLETE) && (owner_q == OWN_A);
    b_ack_d = (state_d == COMPLETE) && (state_q != COMPLETE) && (owner_q == OWN_B);
  end

  // State and output registers; reset drops any transaction without an ack
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= OWN_NONE;
      last_b_q      <= 1'b1;
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      mem_request_q <= 1'b0;
      a_ack_q       <= 1'b0;
      b_ack_q       <= 1'b0;
      a_rdata_q     <= '0;
      b_rdata_q     <= '0;
`ifdef SRAM_ARB_TIMEOUT_EN
      cnt_q         <= '0;
      terr_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_b_q      <= last_b_d;
      addr_q        <= addr_d;
      we_q          <= we_d;
      wdata_q       <= wdata_d;
      mem_request_q <= mem_request_d;
      a_ack_q       <= a_ack_d;
      b_ack_q       <= b_ack_d;
      a_rdata_q     <= a_rdata_d;
      b_rdata_q     <= b_rdata_d;
`ifdef SRAM_ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
      terr_q        <= terr_d;
`endif
    end
  end

  assign bus.mem_request      = mem_request_q;
  assign bus.mem_address      = addr_q;
  assign bus.mem_write_enable = we_q;
  assign bus.mem_write_data   = wdata_q;
  assign bus.owner            = owner_q;
  assign bus.a_ack            = a_ack_q;
  assign bus.b_ack            = b_ack_q;
  assign bus.a_rdata          = a_rdata_q;
  assign bus.b_rdata          = b_rdata_q;
`ifdef SRAM_ARB_TIMEOUT_EN
  assign timeout_err          = terr_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a small busy/read-data encoder
// model. The watchdog case is built only with SRAM_ARB_TIMEOUT_EN.
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(16)) ifc ();

`ifdef SRAM_ARB_TIMEOUT_EN
  logic terr;
  sram_port_arbiter #(.DATA_WIDTH(16), .ADDRESS_WIDTH(16), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .reset(reset), .timeout_err(terr), .bus(ifc));
`else
  sram_port_arbiter #(.DATA_WIDTH(16), .ADDRESS_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .bus(ifc));
`endif

  int total = 0;
  int bad   = 0;

  // encoder model: busy rises right after a request, stays busy_len cycles
  int          busy_len = 20;
  bit          enc_en   = 1'b1;
  int          bcnt     = 0;
  logic [15:0] rd_val   = 16'h0000;
  assign ifc.mem_read_data = rd_val;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      ifc.mem_busy = 1'b0;
      bcnt = 0;
    end else if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) ifc.mem_busy = 1'b0;
    end else if (ifc.mem_request && enc_en) begin
      ifc.mem_busy = 1'b1;
      bcnt = busy_len;
    end
  end

  // pulse counters, sampled away from the active edge
  int n_mreq = 0, n_aack = 0, n_back = 0, b_in_load = 0;
  always @(negedge clk) begin
    if (ifc.mem_request) n_mreq++;
    if (ifc.a_ack) n_aack++;
    if (ifc.b_ack) n_back++;
    if (ifc.owner == 2'b10 && ifc.load_mode) b_in_load++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic clr_cnt();
    n_mreq = 0; n_aack = 0; n_back = 0; b_in_load = 0;
  endtask

  // which: 1 = A acked, 2 = B acked, 0 = none within the budget
  task automatic wait_ack(output int which);
    which = 0;
    for (int i = 0; i < 400; i++) begin
      tick(1);
      if (ifc.a_ack) begin which = 1; break; end
      if (ifc.b_ack) begin which = 2; break; end
    end
    if (which == 0) chk("ack_timeout", 0, 1);
  endtask

  int w;

  initial begin
    ifc.load_mode = 0; ifc.mem_initialized = 0; ifc.mem_busy = 0;
    ifc.a_req = 0; ifc.a_we = 0; ifc.a_addr = 0; ifc.a_wdata = 0;
    ifc.b_req = 0; ifc.b_we = 0; ifc.b_addr = 0; ifc.b_wdata = 0;
    do_reset();

    // reset state
    chk("rst_owner", ifc.owner, 0);
    chk("rst_mreq", ifc.mem_request, 0);
    chk("rst_addr", ifc.mem_address, 0);
    chk("rst_acks", {ifc.a_ack, ifc.b_ack}, 0);
    chk("rst_rdata", {ifc.a_rdata, ifc.b_rdata}, 0);
`ifdef SRAM_ARB_TIMEOUT_EN
    chk("rst_terr", terr, 0);
`endif

    // single read, no contention
    ifc.mem_initialized = 1; busy_len = 20; rd_val = 16'hEC10;
    tick(2); clr_cnt();
    ifc.a_we = 0; ifc.a_addr = 16'h0010; ifc.a_req = 1;
    tick(1);
    chk("t1_grant_owner", ifc.owner, 2'b01);
    chk("t1_addr", ifc.mem_address, 16'h0010);
    chk("t1_mreq_c1", ifc.mem_request, 0);
    tick(1);
    chk("t1_mreq_c2", ifc.mem_request, 1);
    wait_ack(w);
    ifc.a_req = 0;
    chk("t1_ack_port", w, 1);
    chk("t1_rdata", ifc.a_rdata, 16'hEC10);
    chk("t1_b_rdata", ifc.b_rdata, 0);
    tick(3);
    chk("t1_n_mreq", n_mreq, 1);
    chk("t1_n_aack", n_aack, 1);
    chk("t1_n_back", n_back, 0);

    // simultaneous requests: round-robin from reset gives A,B,A,B
    do_reset(); busy_len = 4; rd_val = 16'h0BB0;
    ifc.a_addr = 16'h0100; ifc.b_addr = 16'h0200; ifc.b_we = 0;
    ifc.a_req = 1; ifc.b_req = 1;
    for (int t = 0; t < 4; t++) begin
      wait_ack(w);
      chk("rr_order", w, (t % 2 == 0) ? 1 : 2);
      chk("rr_owner", ifc.owner, (t % 2 == 0) ? 2'b01 : 2'b10);
      if (w == 1) ifc.a_req = 0;
      if (w == 2) ifc.b_req = 0;
      tick(1);
      ifc.a_req = 1; ifc.b_req = 1;
    end
    ifc.a_req = 0; ifc.b_req = 0;
    tick(12);

    // load_mode exclusion
    do_reset(); clr_cnt(); rd_val = 16'h7777;
    ifc.load_mode = 1;
    ifc.a_we = 1; ifc.a_addr = 16'h0003; ifc.a_wdata = 16'h1234; ifc.a_req = 1;
    ifc.b_we = 0; ifc.b_addr = 16'h0042; ifc.b_req = 1;
    tick(1);
    chk("ld_owner", ifc.owner, 2'b01);
    chk("ld_wr", {ifc.mem_write_enable, ifc.mem_address, ifc.mem_write_data},
        {1'b1, 16'h0003, 16'h1234});
    wait_ack(w);
    ifc.a_req = 0;
    chk("ld_ack_port", w, 1);
    chk("ld_wr_rdata", ifc.a_rdata, 0);
    tick(10);
    chk("ld_excl", b_in_load, 0);
    chk("ld_owner_idle", ifc.owner, 0);
    ifc.load_mode = 0;
    tick(1);
    chk("ld_b_grant", ifc.owner, 2'b10);
    wait_ack(w);
    ifc.b_req = 0;
    chk("ld_b_ack", w, 2);
    chk("ld_b_rdata", ifc.b_rdata, 16'h7777);
    chk("ld_a_rdata_keep", ifc.a_rdata, 0);
    tick(3);

    // not initialized
    do_reset(); ifc.mem_initialized = 0; clr_cnt();
    ifc.a_we = 0; ifc.a_req = 1;
    tick(50);
    chk("ni_mreq", n_mreq, 0);
    chk("ni_owner", ifc.owner, 0);
    ifc.mem_initialized = 1;
    tick(1);
    chk("ni_mreq_c1", ifc.mem_request, 0);
    tick(1);
    chk("ni_mreq_c2", ifc.mem_request, 1);
    wait_ack(w);
    ifc.a_req = 0;
    tick(3);

    // reset during WAIT_DONE, after a read has left data in a_rdata
    do_reset(); busy_len = 6; rd_val = 16'h5A5A;
    ifc.a_we = 0; ifc.a_addr = 16'h0011; ifc.a_req = 1;
    wait_ack(w);
    ifc.a_req = 0;
    chk("rm_pre_rdata", ifc.a_rdata, 16'h5A5A);
    tick(2);
    busy_len = 30; ifc.a_addr = 16'h00FF; ifc.a_wdata = 16'hBEEF; ifc.a_req = 1;
    tick(6);
    chk("rm_mid_owner", ifc.owner, 2'b01);
    clr_cnt();
    reset = 1; ifc.a_req = 0;
    tick(1);
    chk("rm_owner", ifc.owner, 0);
    chk("rm_outs", {ifc.mem_request, ifc.mem_write_enable, ifc.mem_address,
                    ifc.mem_write_data}, 0);
    chk("rm_rdata", {ifc.a_rdata, ifc.b_rdata}, 0);
    reset = 0;
    tick(40);
    chk("rm_no_ack", n_aack + n_back, 0);

`ifdef SRAM_ARB_TIMEOUT_EN
    // watchdog: encoder never goes busy
    do_reset(); enc_en = 0;
    ifc.a_we = 0; ifc.a_addr = 16'h0020; ifc.a_req = 1;
    tick(2);
    w = 0;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (ifc.a_ack) begin w = k; break; end
    end
    ifc.a_req = 0;
    chk("to_latency", w, 15);
    chk("to_rdata", ifc.a_rdata, 16'hFFFF);
    chk("to_err", terr, 1);
    tick(5);
    chk("to_err_sticky", terr, 1);
    enc_en = 1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one spi_sram_encoder between two requesters:
  - Port A: ROM stream loader (read/write).
  - Port B: CPU instruction/data fetch (read/write).
- Sits between the requesters and the encoder's request/busy/initialized interface.
- Serialises transactions, arbitrates round-robin, and returns read data with a one-cycle ack.
- A load_mode input gives port A exclusive access during ROM loading.

Parameters:
- DATA_WIDTH, 16, word width of read/write data.
- ADDRESS_WIDTH, 16, word address width.
- TIMEOUT_CYCLES, 1023, watchdog limit. Used only with the optional feature.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- load_mode  input  1  1 = only port A may be granted
- a_req  input  1  port A request; held until a_ack
- a_we  input  1  port A write enable
- a_addr  input  ADDRESS_WIDTH  port A address
- a_wdata  input  DATA_WIDTH  port A write data
- a_ack  output  1  one-cycle completion pulse
- a_rdata  output  DATA_WIDTH  port A read data; valid when a_ack=1
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same as port A, for port B
- mem_request  output  1  one-cycle start pulse to the encoder
- mem_busy  input  1  encoder busy
- mem_initialized  input  1  encoder finished SRAM mode setup
- mem_address  output  ADDRESS_WIDTH  latched transaction address
- mem_write_enable  output  1  latched transaction direction
- mem_write_data  output  DATA_WIDTH  latched write data
- mem_read_data  input  DATA_WIDTH  encoder read result
- owner  output  2  00 = none, 01 = A, 10 = B

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Round-robin pointer last_grant = B, so A wins the first tie.
- States: IDLE -> ISSUE -> WAIT_START -> WAIT_DONE -> COMPLETE -> IDLE.
- IDLE:
  - No grant is made while mem_initialized=0 or mem_busy=1.
  - Eligible requesters: A if a_req=1; B if b_req=1 and load_mode=0.
  - Exactly one eligible: grant it.
  - Both eligible: grant the one that is not last_grant.
  - On grant, latch addr/we/wdata into mem_* registers, set owner and update last_grant.
- ISSUE: drive mem_request=1 for exactly one cycle, then go to WAIT_START.
- WAIT_START: wait for mem_busy=1.
- WAIT_DONE:
  - Wait for mem_busy=0.
  - On that cycle, capture mem_read_data into the owner's rdata register.
- COMPLETE:
  - Pulse the owner's ack for one cycle.
  - Clear owner to 00 and return to IDLE.
- Grant latency: a request arriving in IDLE issues mem_request 2 cycles after req rises (grant cycle, then ISSUE).
- Back-to-back transactions: the earliest next grant is the cycle after COMPLETE.
- Write transactions: rdata is left unchanged; ack is still pulsed.
- req dropped before grant: no transaction occurs.
- req dropped after grant: the transaction completes and ack is still pulsed. The requester must ignore it.
- mem_* outputs hold stable from grant until the ack cycle. Changes on requester inputs after grant are ignored.
- load_mode rising while B owns the bus: B's transaction completes normally. Later B requests wait until load_mode=0.
- rdata of the non-owner port never changes.
- Reset mid-transaction: state returns to IDLE immediately and no ack is issued. The encoder has its own reset.

Optional Feature:
- Macro: SRAM_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_START and WAIT_DONE and clears on every state change.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to COMPLETE and acks the owner with rdata forced to all-ones.
  - Sticky output timeout_err (1 bit) is set; only reset clears it.
- Not defined:
  - No counter and no timeout_err port.
  - The FSM waits indefinitely on mem_busy.

Test Plan:
- Single read, no contention:
  - Stimulus: after mem_initialized=1, a_req with a_we=0, a_addr=0x0010; encoder model holds busy for 20 cycles and returns 0xEC10.
  - Response: mem_request pulses once at cycle 2; a_ack pulses once; a_rdata=0xEC10; b_ack stays 0.
- Simultaneous requests:
  - Stimulus: a_req and b_req asserted in the same cycle, held, and re-asserted after each ack for 4 transactions.
  - Response: grant order A, B, A, B; owner sequence 01, 10, 01, 10.
- load_mode exclusion:
  - Stimulus: load_mode=1; a_req writes 0x1234 to 0x0003; b_req held high.
  - Response: no B grant while load_mode=1. After load_mode falls, B is served within 2 cycles.
- Not initialized:
  - Stimulus: a_req asserted while mem_initialized=0 for 50 cycles.
  - Response: mem_request stays 0. After initialized rises, the first mem_request follows 2 cycles later.
- Reset mid-transaction:
  - Stimulus: assert reset during WAIT_DONE.
  - Response: next cycle owner=00; a_ack never pulses; all outputs are 0.
- Timeout (with SRAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=15):
  - Stimulus: mem_busy never rises.
  - Response: a_ack pulses 15 cycles after entering WAIT_START; a_rdata=0xFFFF; timeout_err=1.
